adder_response_checker: RTL and testbench

- Synthesizable response checker for the 4-bit look-ahead adder; the consuming end of the exhaustive stimulus sweep.
- Samples {A, B, SUM} beats qualified by in_valid and compares each SUM against a registered golden A+B.
- Counts mismatches, captures the first failing vector, and tracks coverage of all 2^(2*DATA_W) input combinations.
- Reports done/pass so benches and on-board builds get a single verdict without waveform inspection.

---
 rtl/adder_chk_pkg.sv | 20 ++
 rtl/vector_coverage_map.sv | 33 +++
 rtl/adder_response_checker.sv | 114 +++++++++++
 tb/tb_adder_response_checker.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_chk_pkg.sv
// Shared constants, state encoding and reference model for the 4-bit adder response checker.
package adder_chk_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int CNT_W_DEF  = 16;
    localparam int NUM_VEC    = 1 << (2 * DATA_W_DEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Full-width sum: the carry-out is part of the expected response.
    function automatic logic [DATA_W_DEF:0] golden_sum(input logic [DATA_W_DEF-1:0] a,
                                                      input logic [DATA_W_DEF-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/vector_coverage_map.sv
// One bit per {a,b} input combination; counts how many distinct combinations have been seen.
module vector_coverage_map #(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    output logic [IDX_W:0]   covered_count,
    output logic             full
);

    localparam int NUM = 1 << IDX_W;

    logic [NUM-1:0] map;
    logic           hit_new;

    // Only a first hit on a bit advances the count, so duplicates never inflate coverage.
    assign hit_new = set_en && !map[set_idx];
    assign full    = (covered_count == (IDX_W + 1)'(NUM));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            map           <= '0;
            covered_count <= '0;
        end else if (hit_new) begin
            map[set_idx]  <= 1'b1;
            covered_count <= covered_count + 1'b1;
        end
    end

endmodule

// File: rtl/adder_response_checker.sv
// Two-stage response checker: stage 1 registers the beat and its golden sum, stage 2 scores it.
module adder_response_checker
    import adder_chk_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [DATA_W:0]     sum,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [CNT_W-1:0]    sample_count,
    output logic [CNT_W-1:0]    err_count,
    output logic [2*DATA_W:0]   covered_count,
    output logic                first_err_valid,
    output logic [DATA_W-1:0]   first_err_a,
    output logic [DATA_W-1:0]   first_err_b,
    output logic [DATA_W:0]     first_err_sum
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]        state;
    logic              stop_pending;
    logic              accept;
    logic              s1_valid;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;
    logic [DATA_W:0]   s1_sum;
    logic [DATA_W:0]   s1_exp;
    logic              mismatch;
    logic              cov_full;
    logic              drained;

    // Once stop is seen no new beats enter; the pipeline only drains.
    assign accept   = (state == S_RUN) && in_valid && !start && !stop_pending;
    assign mismatch = (s1_sum != s1_exp);
    assign drained  = !s1_valid && !accept;
    assign busy     = (state == S_RUN);
    assign done     = (state == S_DONE);

    vector_coverage_map #(.IDX_W(2 * DATA_W)) u_cov (
        .clk           (clk),
        .reset         (reset),
        .clear         (start),
        .set_en        (s1_valid),
        .set_idx       ({s1_a, s1_b}),
        .covered_count (covered_count),
        .full          (cov_full)
    );

    always_ff @(posedge clk) begin
        if (reset || start) begin
            state           <= reset ? S_IDLE : S_RUN;
            stop_pending    <= 1'b0;
            pass            <= 1'b0;
            s1_valid        <= 1'b0;
            s1_a            <= '0;
            s1_b            <= '0;
            s1_sum          <= '0;
            s1_exp          <= '0;
            sample_count    <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
            first_err_sum   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_a   <= a;
                s1_b   <= b;
                s1_sum <= sum;
                s1_exp <= {1'b0, a} + {1'b0, b};
            end

            if (s1_valid) begin
                if (sample_count != '1)
                    sample_count <= sample_count + 1'b1;
                if (mismatch) begin
                    if (err_count != '1)
                        err_count <= err_count + 1'b1;
                    if (!first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_a     <= s1_a;
                        first_err_b     <= s1_b;
                        first_err_sum   <= s1_sum;
                    end
                end
            end

            // Counters are final whenever the pipeline is empty, so pass sees settled values.
            if (state == S_RUN) begin
                if (stop)
                    stop_pending <= 1'b1;
                if ((stop_pending || stop || cov_full) && drained) begin
                    state        <= S_DONE;
                    stop_pending <= 1'b0;
                    pass         <= (err_count == '0) && cov_full;
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_response_checker.sv
// Directed bench for adder_response_checker: scenario table plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_adder_response_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic [4:0] sum = '0;
    logic        busy, done, pass, first_err_valid;
    logic [15:0] sample_count, err_count;
    logic [8:0]  covered_count;
    logic [3:0]  first_err_a, first_err_b;
    logic [4:0]  first_err_sum;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         n_beats;
        logic       inject;
        logic [7:0] bad_idx;
        logic [4:0] bad_sum;
        int         dup0;
        logic       gaps;
        int         use_stop;   // 0 none, 1 after last beat, 2 with last beat
        int         exp_samples;
        int         exp_errs;
        int         exp_cov;
        logic       exp_pass;
        logic       exp_fev;
        logic [3:0] exp_fa;
        logic [3:0] exp_fb;
        logic [4:0] exp_fsum;
    } scen_t;

    scen_t scen[5];

    adder_response_checker dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .stop            (stop),
        .in_valid        (in_valid),
        .a               (a),
        .b               (b),
        .sum             (sum),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .sample_count    (sample_count),
        .err_count       (err_count),
        .covered_count   (covered_count),
        .first_err_valid (first_err_valid),
        .first_err_a     (first_err_a),
        .first_err_b     (first_err_b),
        .first_err_sum   (first_err_sum)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] va, input logic [3:0] vb, input logic [4:0] vs);
        in_valid = 1'b1;
        a = va;
        b = vb;
        sum = vs;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_pass"}, 32'(pass), 0);
        check({tag, "_samples"}, 32'(sample_count), 0);
        check({tag, "_errs"}, 32'(err_count), 0);
        check({tag, "_cov"}, 32'(covered_count), 0);
        check({tag, "_fev"}, 32'(first_err_valid), 0);
        check({tag, "_fa"}, 32'(first_err_a), 0);
        check({tag, "_fb"}, 32'(first_err_b), 0);
        check({tag, "_fsum"}, 32'(first_err_sum), 0);
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!done && k < 10) begin
            tick();
            k++;
        end
        check({tag, "_done_reached"}, 32'(done), 1);
    endtask

    function automatic scen_t mk(int n, logic inj, logic [7:0] bi, logic [4:0] bs, int d0,
                                 logic g, int us, int es, int ee, int ec, logic ep,
                                 logic ef, logic [3:0] fa, logic [3:0] fb, logic [4:0] fs);
        scen_t s;
        s.n_beats = n;  s.inject = inj;  s.bad_idx = bi;  s.bad_sum = bs;
        s.dup0 = d0;    s.gaps = g;      s.use_stop = us;
        s.exp_samples = es; s.exp_errs = ee; s.exp_cov = ec; s.exp_pass = ep;
        s.exp_fev = ef; s.exp_fa = fa; s.exp_fb = fb; s.exp_fsum = fs;
        return s;
    endfunction

    task automatic run_scen(input scen_t s, input bit do_start, input string tag);
        logic [7:0] idx;
        logic [4:0] vs;
        if (do_start) begin
            pulse_start();
            check({tag, "_busy_after_start"}, 32'(busy), 1);
            check({tag, "_samples_after_start"}, 32'(sample_count), 0);
        end
        for (int i = 0; i < s.n_beats; i++) begin
            idx = 8'(i);
            vs = {1'b0, idx[7:4]} + {1'b0, idx[3:0]};
            if (s.inject && idx == s.bad_idx)
                vs = s.bad_sum;
            if (i == 0)
                repeat (s.dup0) beat(4'h0, 4'h0, 5'h00);
            if (s.use_stop == 2 && i == s.n_beats - 1)
                stop = 1'b1;
            beat(idx[7:4], idx[3:0], vs);
            stop = 1'b0;
            if (s.gaps && (i % 8 == 3) && i != s.n_beats - 1)
                idle((i % 3) + 1);
        end
        if (s.use_stop == 1) begin
            stop = 1'b1;
            tick();
            stop = 1'b0;
        end
        if (s.use_stop == 0) begin
            tick();
            check({tag, "_done_not_early"}, 32'(done), 0);
            tick();
            check({tag, "_done_at_t3"}, 32'(done), 1);
        end else begin
            wait_done(tag);
        end
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_samples"}, 32'(sample_count), 32'(s.exp_samples));
        check({tag, "_errs"}, 32'(err_count), 32'(s.exp_errs));
        check({tag, "_cov"}, 32'(covered_count), 32'(s.exp_cov));
        check({tag, "_pass"}, 32'(pass), 32'(s.exp_pass));
        check({tag, "_fev"}, 32'(first_err_valid), 32'(s.exp_fev));
        if (s.exp_fev) begin
            check({tag, "_fa"}, 32'(first_err_a), 32'(s.exp_fa));
            check({tag, "_fb"}, 32'(first_err_b), 32'(s.exp_fb));
            check({tag, "_fsum"}, 32'(first_err_sum), 32'(s.exp_fsum));
        end
    endtask

    // ---------------- test ----------------
    initial begin
        scen[0] = mk(256, 0, 8'h00, 5'h00, 0, 0, 0, 256, 0, 256, 1, 0, 4'h0, 4'h0, 5'h00);
        scen[1] = mk(256, 1, 8'hF1, 5'h00, 0, 0, 0, 256, 1, 256, 0, 1, 4'hF, 4'h1, 5'h00);
        scen[2] = mk(10,  0, 8'h00, 5'h00, 0, 0, 1, 10,  0, 10,  0, 0, 4'h0, 4'h0, 5'h00);
        scen[3] = mk(256, 0, 8'h00, 5'h00, 2, 1, 0, 258, 0, 256, 1, 0, 4'h0, 4'h0, 5'h00);
        scen[4] = mk(10,  1, 8'h03, 5'h1F, 0, 0, 2, 10,  1, 10,  0, 1, 4'h0, 4'h3, 5'h1F);

        repeat (3) tick();
        check_zero_outputs("reset");
        reset = 1'b0;
        tick();
        check_zero_outputs("idle");

        for (int s = 0; s < 5; s++)
            run_scen(scen[s], 1'b1, $sformatf("scen%0d", s));

        // Mid-sweep reset: in-flight work discarded, beats ignored until start.
        pulse_start();
        for (int i = 0; i < 100; i++)
            beat(4'(i >> 4), 4'(i), 5'((i >> 4) + (i & 15)));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_zero_outputs("midreset");
        for (int i = 0; i < 5; i++)
            beat(4'(i), 4'(i), 5'(2 * i));
        idle(3);
        check("noStart_samples", 32'(sample_count), 0);
        check("noStart_cov", 32'(covered_count), 0);
        check("noStart_busy", 32'(busy), 0);
        run_scen(scen[0], 1'b1, "after_reset");

        // Restart during RUN with a concurrent (wrong) beat: that beat must be dropped.
        pulse_start();
        for (int i = 0; i < 20; i++)
            beat(4'(i >> 4), 4'(i), 5'((i >> 4) + (i & 15)));
        start = 1'b1;
        beat(4'h0, 4'h0, 5'h1F);
        start = 1'b0;
        check("restart_busy", 32'(busy), 1);
        check("restart_samples", 32'(sample_count), 0);
        check("restart_cov", 32'(covered_count), 0);
        idle(2);
        check("restart_samples_late", 32'(sample_count), 0);
        check("restart_errs_late", 32'(err_count), 0);
        run_scen(scen[0], 1'b0, "restart_sweep");

        // Beats in DONE are dropped; start with stop together restarts.
        for (int i = 0; i < 3; i++)
            beat(4'h1, 4'h1, 5'h03);
        idle(3);
        check("done_hold", 32'(done), 1);
        check("done_drop_samples", 32'(sample_count), 256);
        check("done_drop_errs", 32'(err_count), 0);
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        check("startstop_busy", 32'(busy), 1);
        check("startstop_done", 32'(done), 0);
        check("startstop_pass", 32'(pass), 0);
        check("startstop_samples", 32'(sample_count), 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done("empty_stop");
        check("empty_stop_cov", 32'(covered_count), 0);
        check("empty_stop_pass", 32'(pass), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
